// File: rtl/tri_bus_arbiter_pkg.sv
// Shared types and helpers for the tri-state bus arbiter.
// Optional hold-timeout feature: TRI_BUS_ARB_TIMEOUT_EN.
package tri_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arbState_t;

  localparam int MAX_N = 8;

  // Owner index width; never narrower than one bit.
  function automatic int ownerWidth(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/tri_bus_arbiter_if.sv
// Request/grant bundle between requester logic and the bus arbiter.
// The master side drives requests; the slave side is the arbiter.
interface tri_bus_arb_if #(
  parameter int N = 4
) ();
  import tri_bus_arb_pkg::*;

  localparam int OW = ownerWidth(N);

  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [N-1:0]  oe;
  logic [OW-1:0] owner;
  logic          busy;

  modport master (output req, input gnt, input oe, input owner, input busy);
  modport slave  (input req, output gnt, output oe, output owner, output busy);

endinterface

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Cyclic first-set picker: returns the first asserted request found
// scanning from the priority pointer upward and wrapping at N-1.
module rr_pick
  import tri_bus_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = ownerWidth(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_idx,
  output logic         o_valid
);

  int w_pos;

  // Scan from the farthest position back to the pointer so the closest hit wins.
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    w_pos   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = (int'(i_ptr) + k) % N;
      if (i_req[w_pos]) o_idx = W'(w_pos);
    end
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner selection for a shared tristated pin group.
// Grants are one-hot and double as the TRI enables; a fixed idle gap of
// TURN_CYC cycles separates consecutive owners so drivers never overlap.
// Define TRI_BUS_ARB_TIMEOUT_EN to cap each ownership at MAX_HOLD cycles.
module tri_bus_arbiter
  import tri_bus_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  tri_bus_arb_if.slave  bus
);

  localparam int W = ownerWidth(N);

  arbState_t    r_state;
  logic [W-1:0] r_ptr;
  logic [W-1:0] r_owner;
  logic [1:0]   r_turnCnt;
  logic [N-1:0] r_gnt;
  logic [N-1:0] r_oe;
  logic         r_busy;

  logic [W-1:0] w_pickIdx;
  logic         w_pickValid;
  logic         w_release;
  logic         w_holdExpired;

  rr_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_idx   (w_pickIdx),
    .o_valid (w_pickValid)
  );

`ifdef TRI_BUS_ARB_TIMEOUT_EN
  logic [7:0] r_holdCnt;

  // Counts owned cycles; preloaded to 1 outside OWN so a fresh grant starts at 1.
  always_ff @(posedge i_clk) begin
    if (i_rst)                r_holdCnt <= 8'd0;
    else if (r_state == OWN)  r_holdCnt <= r_holdCnt + 8'd1;
    else                      r_holdCnt <= 8'd1;
  end

  assign w_holdExpired = (r_holdCnt == 8'(MAX_HOLD));
`else
  // Without the timeout the hold limit never fires (MAX_HOLD is always >= 2).
  assign w_holdExpired = (MAX_HOLD == 0);
`endif

  assign w_release = ~bus.req[r_owner] | w_holdExpired;

  // Ownership state machine with registered grant, enable, owner and busy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_turnCnt <= 2'd0;
      r_gnt     <= '0;
      r_oe      <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, TURN: begin
          if ((r_state == TURN) && (r_turnCnt != 2'd0)) begin
            r_turnCnt <= r_turnCnt - 2'd1;
          end else if (w_pickValid) begin
            r_state <= OWN;
            r_owner <= w_pickIdx;
            r_gnt   <= N'(1) << w_pickIdx;
            r_oe    <= N'(1) << w_pickIdx;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        OWN: begin
          if (w_release) begin
            r_state   <= TURN;
            r_ptr     <= (r_owner == W'(N - 1)) ? '0 : r_owner + 1'b1;
            r_owner   <= '0;
            r_turnCnt <= 2'(TURN_CYC - 1);
            r_gnt     <= '0;
            r_oe      <= '0;
            r_busy    <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.oe    = r_oe;
  assign bus.owner = r_owner;
  assign bus.busy  = r_busy;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Scoreboard bench for tri_bus_arbiter: stimulus pushes the reference
// model's expected outputs, a monitor pops and compares after each edge.
module tb_tri_bus_arbiter;

  localparam int N    = 4;
  localparam int TURN = 2;
  localparam int MAXH = 4;

`ifdef TRI_BUS_ARB_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  tri_bus_arb_if #(.N(N)) bus ();

  tri_bus_arbiter #(
    .N        (N),
    .TURN_CYC (TURN),
    .MAX_HOLD (MAXH)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] gnt;
    logic [N-1:0] oe;
    logic [1:0]   owner;
    logic         busy;
  } exp_t;

  exp_t expQ[$];
  int   nVec = 0;
  int   nMis = 0;

  // Reference model: owner index (-1 = nobody), edges left before a pick may
  // happen, rotating priority start, and cycles held by the current owner.
  int mOwner = -1;
  int mWait  = 0;
  int mPtr   = 0;
  int mHeld  = 0;

  function automatic int modelPick(input logic [N-1:0] req);
    for (int k = 0; k < N; k++) begin
      if (req[(mPtr + k) % N]) return (mPtr + k) % N;
    end
    return -1;
  endfunction

  task automatic modelStep(input logic r, input logic [N-1:0] req);
    if (r) begin
      mOwner = -1; mWait = 0; mPtr = 0; mHeld = 0;
    end else if (mOwner >= 0) begin
      if (!req[mOwner] || (TIMEOUT && mHeld == MAXH)) begin
        mPtr   = (mOwner + 1) % N;
        mOwner = -1;
        mWait  = TURN;
      end else begin
        mHeld++;
      end
    end else if (mWait > 1) begin
      mWait--;
    end else begin
      mWait  = 0;
      mOwner = modelPick(req);
      if (mOwner >= 0) mHeld = 1;
    end
  endtask

  // Drive one cycle of inputs and queue the outputs the next edge must produce.
  task automatic applyStimulus(input logic r, input logic [N-1:0] req);
    exp_t e;
    @(negedge clk);
    rst     = r;
    bus.req = req;
    modelStep(r, req);
    e.gnt = '0;
    if (mOwner >= 0) e.gnt[mOwner] = 1'b1;
    e.oe    = e.gnt;
    e.owner = (mOwner >= 0) ? 2'(mOwner) : 2'd0;
    e.busy  = (mOwner >= 0);
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    nVec++;
    if (bus.gnt !== e.gnt || bus.oe !== e.oe || bus.owner !== e.owner || bus.busy !== e.busy) begin
      nMis++;
      $display("[TB] FAIL vec%0d t=%0t got gnt=%b oe=%b owner=%0d busy=%b, want gnt=%b oe=%b owner=%0d busy=%b",
               nVec, $time, bus.gnt, bus.oe, bus.owner, bus.busy, e.gnt, e.oe, e.owner, e.busy);
    end
  endtask

  // Monitor: every output settles after the edge; compare against the queue head.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  logic [N-1:0] want;
  logic [N-1:0] rq;

  initial begin
    rst     = 1'b1;
    bus.req = '0;

    // Reset held with every request asserted, then first grant to requester 0.
    repeat (3) applyStimulus(1'b1, 4'b1111);
    repeat (3) applyStimulus(1'b0, 4'b1111);
    repeat (4) applyStimulus(1'b0, 4'b0000);

    // Single requester for five cycles.
    repeat (5) applyStimulus(1'b0, 4'b0100);
    repeat (4) applyStimulus(1'b0, 4'b0000);

    // Rotation: everyone requests, each owner drops after two owned cycles.
    for (int i = 0; i < 30; i++) begin
      rq = 4'b1111;
      if (mOwner >= 0 && mHeld >= 2) rq[mOwner] = 1'b0;
      applyStimulus(1'b0, rq);
    end
    repeat (4) applyStimulus(1'b0, 4'b0000);

    // Owner 1 releases on the same edge requester 3 arrives.
    repeat (3) applyStimulus(1'b0, 4'b0010);
    repeat (6) applyStimulus(1'b0, 4'b1000);
    repeat (4) applyStimulus(1'b0, 4'b0000);

    // Reset while requester 1 owns the bus.
    repeat (3) applyStimulus(1'b0, 4'b0010);
    applyStimulus(1'b1, 4'b0010);
    repeat (3) applyStimulus(1'b0, 4'b0010);
    repeat (4) applyStimulus(1'b0, 4'b0000);

    // Two steady requesters: timeout alternates them, otherwise 0 keeps it.
    repeat (20) applyStimulus(1'b0, 4'b0011);
    repeat (4) applyStimulus(1'b0, 4'b0000);

    // Random level-held requests with occasional resets.
    want = '0;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < N; b++) begin
        if (want[b]) begin
          if ($urandom_range(0, 5) == 0) want[b] = 1'b0;
        end else begin
          if ($urandom_range(0, 3) == 0) want[b] = 1'b1;
        end
      end
      applyStimulus($urandom_range(0, 79) == 0, want);
    end
    repeat (2) applyStimulus(1'b0, 4'b0000);

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    #2;
    if (expQ.size() > 0) begin
      nMis++;
      $display("[TB] FAIL drain: %0d expected outputs never checked, want 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
